indication_batcher: RTL and testbench



---
 rtl/indication_batcher.sv | 133 +++++++++++++
 tb/tb_indication_batcher.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/indication_batcher.sv
// rtl/indication_batcher.sv - packs 32-bit indication words into 144-bit pipe messages
//
// Collects up to four heard words and issues them as one message with a
// 16-bit header {METHOD_ID, 5'b0, count}. A partial batch is flushed once
// TIMEOUT cycles pass without a new word (TIMEOUT=0: only full batches).
//
// Ports:
//   CLK          clock, rising edge
//   nRST         synchronous active-low reset
//   heard__ENA   word valid (only while heard__RDY=1)
//   heard_v      32-bit indication word
//   heard__RDY   batcher accepts a word this cycle
//   enq__ENA     message issued this cycle (never without enq__RDY)
//   enq_v        144-bit message: [143:136] method, [130:128] count, [127:0] payload
//   enq__RDY     downstream can accept a message
module indication_batcher #(
    parameter logic [7:0] METHOD_ID = 8'd0,
    parameter int         TIMEOUT   = 16,
    parameter int         TCW       = 8
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         heard__ENA,
    input  logic [31:0]  heard_v,
    output logic         heard__RDY,
    output logic         enq__ENA,
    output logic [143:0] enq_v,
    input  logic         enq__RDY
);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam bit             TO_EN     = (TIMEOUT != 0);
    localparam logic [TCW-1:0] IDLE_LAST = TO_EN ? TCW'(TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [TCW-1:0]      idle_q, idle_d;
    logic [3:0][31:0]    buf_q, buf_d;

    logic accept;
    logic issue;
    logic timeout_hit;

    assign accept = (state_q == FILL) && heard__ENA;
    assign issue  = (state_q == SEND) && enq__RDY;

    // A word arriving on the expiry edge takes priority over the flush.
    assign timeout_hit = TO_EN && (state_q == FILL) && !heard__ENA &&
                         (cnt_q != 3'd0) && (idle_q == IDLE_LAST);

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (accept && (cnt_q == 3'd3)) begin
                    state_d = SEND;
                end else if (timeout_hit) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (issue) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Batch datapath
    always_comb begin
        cnt_d  = cnt_q;
        idle_d = idle_q;
        buf_d  = buf_q;
        if (state_q == FILL) begin
            if (heard__ENA) begin
                buf_d[cnt_q[1:0]] = heard_v;
                cnt_d             = cnt_q + 3'd1;
                idle_d            = '0;
            end else if (cnt_q != 3'd0) begin
                idle_d = idle_q + TCW'(1);
            end
        end else if (issue) begin
            cnt_d  = 3'd0;
            idle_d = '0;
            buf_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q  <= 3'd0;
            idle_q <= '0;
            buf_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            buf_q  <= buf_d;
        end
    end

    // Outputs; everything is forced quiet while reset is asserted so a
    // message pending at reset is dropped without an enq__ENA.
    always_comb begin
        heard__RDY = nRST && (state_q == FILL);
        enq__ENA   = nRST && issue;
        enq_v      = '0;
        if (nRST && (state_q == SEND)) begin
            enq_v[143:136] = METHOD_ID;
            enq_v[130:128] = cnt_q;
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < cnt_q) begin
                    enq_v[32*i +: 32] = buf_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_indication_batcher.sv
// tb/tb_indication_batcher.sv - scoreboard bench for indication_batcher
module tb_indication_batcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut0: METHOD_ID=0, TIMEOUT=16
    logic         nrst0, h0_ena, h0_rdy, e0_ena, e0_rdy;
    logic [31:0]  h0_v;
    logic [143:0] e0_v;
    // dut1: METHOD_ID=0x3C, TIMEOUT=4
    logic         nrst1, h1_ena, h1_rdy, e1_ena, e1_rdy;
    logic [31:0]  h1_v;
    logic [143:0] e1_v;

    indication_batcher #(.METHOD_ID(8'h00), .TIMEOUT(16), .TCW(8)) dut0 (
        .CLK(clk), .nRST(nrst0), .heard__ENA(h0_ena), .heard_v(h0_v),
        .heard__RDY(h0_rdy), .enq__ENA(e0_ena), .enq_v(e0_v), .enq__RDY(e0_rdy)
    );

    indication_batcher #(.METHOD_ID(8'h3C), .TIMEOUT(4), .TCW(8)) dut1 (
        .CLK(clk), .nRST(nrst1), .heard__ENA(h1_ena), .heard_v(h1_v),
        .heard__RDY(h1_rdy), .enq__ENA(e1_ena), .enq_v(e1_v), .enq__RDY(e1_rdy)
    );

    int checks = 0;
    int passed = 0;

    logic [143:0] q0[$];
    logic [143:0] q1[$];
    int ena0_n = 0, ena0_cyc = -1, rdylow0_n = 0;
    int ena1_n = 0, ena1_cyc = -1;

    function automatic logic [143:0] mk(input logic [7:0] mid, input int n,
                                        input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0]  w[4];
        logic [143:0] m;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        m = '0;
        m[143:136] = mid;
        m[130:128] = 3'(n);
        for (int i = 0; i < 4; i++) begin
            if (i < n) m[32*i +: 32] = w[i];
        end
        return m;
    endfunction

    // Output monitors: every issued message is popped from the scoreboard.
    always @(negedge clk) begin
        logic [143:0] exp_v;
        if (e0_ena) begin
            ena0_n++;
            ena0_cyc = cyc;
            checks++;
            if (q0.size() == 0) begin
                $display("FAIL dut0_unexpected_msg got %h want none", e0_v);
            end else begin
                exp_v = q0.pop_front();
                if (e0_v !== exp_v) $display("FAIL dut0_msg got %h want %h", e0_v, exp_v);
                else passed++;
            end
        end
        if (nrst0 && !h0_rdy) rdylow0_n++;
    end

    always @(negedge clk) begin
        logic [143:0] exp_v;
        if (e1_ena) begin
            ena1_n++;
            ena1_cyc = cyc;
            checks++;
            if (q1.size() == 0) begin
                $display("FAIL dut1_unexpected_msg got %h want none", e1_v);
            end else begin
                exp_v = q1.pop_front();
                if (e1_v !== exp_v) $display("FAIL dut1_msg got %h want %h", e1_v, exp_v);
                else passed++;
            end
        end
    end

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            checks++; if (h0_rdy !== 1'b0) $display("FAIL rst_rdy0 got %b want 0", h0_rdy); else passed++;
            checks++; if (e0_ena !== 1'b0) $display("FAIL rst_ena0 got %b want 0", e0_ena); else passed++;
            checks++; if (e0_v !== 144'd0) $display("FAIL rst_v0 got %h want 0", e0_v); else passed++;
            checks++; if (h1_rdy !== 1'b0) $display("FAIL rst_rdy1 got %b want 0", h1_rdy); else passed++;
        end
        @(posedge clk); #1;
        nrst0 = 1'b1;
        nrst1 = 1'b1;
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1) $display("FAIL rel_rdy0 got %b want 1", h0_rdy); else passed++;
        checks++; if (h1_rdy !== 1'b1) $display("FAIL rel_rdy1 got %b want 1", h1_rdy); else passed++;
    endtask

    task automatic test_full_batch();
        logic [31:0] w[4];
        int base, rl, e4;
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        @(posedge clk); #1;
        e0_rdy = 1'b1;
        base = ena0_n;
        rl = rdylow0_n;
        q0.push_back(mk(8'h00, 4, w[0], w[1], w[2], w[3]));
        for (int i = 0; i < 4; i++) begin
            h0_ena = 1'b1;
            h0_v = w[i];
            @(posedge clk); #1;
        end
        h0_ena = 1'b0;
        e4 = cyc;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (ena0_n - base !== 1) $display("FAIL full_ena_count got %0d want 1", ena0_n - base); else passed++;
        checks++; if (ena0_cyc !== e4) $display("FAIL full_latency got %0d want %0d", ena0_cyc, e4); else passed++;
        checks++; if (rdylow0_n - rl !== 1) $display("FAIL full_rdy_low got %0d want 1", rdylow0_n - rl); else passed++;
    endtask

    task automatic test_timeout();
        int base, n;
        bit seen;
        base = ena0_n;
        q0.push_back(mk(8'h00, 1, 32'hDEADBEEF, 0, 0, 0));
        h0_ena = 1'b1;
        h0_v = 32'hDEADBEEF;
        @(posedge clk); #1;
        h0_ena = 1'b0;
        n = cyc;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            if (ena0_n != base) seen = 1;
        end
        checks++; if (!seen) $display("FAIL timeout_wait got none want msg"); else passed++;
        checks++; if (ena0_cyc !== n + 16) $display("FAIL timeout_latency got %0d want %0d", ena0_cyc, n + 16); else passed++;
    endtask

    task automatic test_backpressure();
        logic [143:0] snap;
        int base;
        @(posedge clk); #1;
        e0_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            h0_ena = 1'b1;
            h0_v = 32'hA000_0000 + 32'(i);
            @(posedge clk); #1;
        end
        h0_ena = 1'b0;
        q0.push_back(mk(8'h00, 4, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003));
        base = ena0_n;
        @(negedge clk);
        snap = e0_v;
        repeat (10) begin
            @(negedge clk);
            checks++; if (e0_ena !== 1'b0) $display("FAIL bp_ena got %b want 0", e0_ena); else passed++;
            checks++; if (e0_v !== snap) $display("FAIL bp_stable got %h want %h", e0_v, snap); else passed++;
            checks++; if (h0_rdy !== 1'b0) $display("FAIL bp_rdy got %b want 0", h0_rdy); else passed++;
        end
        @(posedge clk); #1;
        e0_rdy = 1'b1;
        @(negedge clk);
        checks++; if (e0_ena !== 1'b1) $display("FAIL bp_release_ena got %b want 1", e0_ena); else passed++;
        @(negedge clk);
        checks++; if (h0_rdy !== 1'b1) $display("FAIL bp_after_rdy got %b want 1", h0_rdy); else passed++;
        #1;
        checks++; if (ena0_n - base !== 1) $display("FAIL bp_ena_count got %0d want 1", ena0_n - base); else passed++;
    endtask

    task automatic test_timeout_race();
        int base, n;
        bit seen;
        base = ena1_n;
        q1.push_back(mk(8'h3C, 2, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0));
        @(posedge clk); #1;
        h1_ena = 1'b1;
        h1_v = 32'hAAAA_0001;
        @(posedge clk); #1;
        h1_ena = 1'b0;
        n = cyc;
        repeat (3) @(posedge clk);
        #1;
        h1_ena = 1'b1;
        h1_v = 32'hBBBB_0002;
        @(posedge clk); #1;
        h1_ena = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); #1;
            if (ena1_n != base) seen = 1;
        end
        checks++; if (!seen) $display("FAIL race_wait got none want msg"); else passed++;
        checks++; if (ena1_cyc !== n + 8) $display("FAIL race_latency got %0d want %0d", ena1_cyc, n + 8); else passed++;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ena1_n - base !== 1) $display("FAIL race_ena_count got %0d want 1", ena1_n - base); else passed++;
    endtask

    task automatic test_reset_mid_send();
        int base;
        bit seen;
        @(posedge clk); #1;
        e0_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            h0_ena = 1'b1;
            h0_v = 32'hCC00_0000 + 32'(i);
            @(posedge clk); #1;
        end
        h0_ena = 1'b0;
        base = ena0_n;
        nrst0 = 1'b0;
        e0_rdy = 1'b1;
        @(negedge clk);
        checks++; if (e0_ena !== 1'b0) $display("FAIL rms_ena got %b want 0", e0_ena); else passed++;
        checks++; if (h0_rdy !== 1'b0) $display("FAIL rms_rdy got %b want 0", h0_rdy); else passed++;
        @(posedge clk); #1;
        nrst0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ena0_n !== base) $display("FAIL rms_dropped got %0d want %0d", ena0_n, base); else passed++;
        q0.push_back(mk(8'h00, 4, 32'h1, 32'h2, 32'h3, 32'h4));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            h0_ena = 1'b1;
            h0_v = 32'(i + 1);
            @(posedge clk); #1;
        end
        h0_ena = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk); #1;
            if (ena0_n != base) seen = 1;
        end
        checks++; if (!seen) $display("FAIL rms_new_batch got none want msg"); else passed++;
    endtask

    initial begin
        nrst0 = 1'b0; nrst1 = 1'b0;
        h0_ena = 1'b0; h0_v = '0; e0_rdy = 1'b1;
        h1_ena = 1'b0; h1_v = '0; e1_rdy = 1'b1;
        test_reset();
        test_full_batch();
        test_timeout();
        test_backpressure();
        test_timeout_race();
        test_reset_mid_send();
        repeat (4) @(negedge clk);
        #1;
        checks++; if (q0.size() !== 0) $display("FAIL q0_drained got %0d want 0", q0.size()); else passed++;
        checks++; if (q1.size() !== 0) $display("FAIL q1_drained got %0d want 0", q1.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
